// File: rtl/systolic_array_drain_pkg.sv
// Shared types and constants for the systolic array drain stage.
// Drain FSM states, row-pointer width and saturation limits.
package systolic_array_drain_pkg;

    typedef enum logic {
        IDLE,
        DRAIN
    } drain_state_e;

    function automatic int row_w(input int y);
        return ($clog2(y) > 0) ? $clog2(y) : 1;
    endfunction

    // Largest representable output value.
    function automatic longint sat_hi(input int w, input bit s);
        return s ? (longint'(1) <<< (w - 1)) - 1
                 : (longint'(1) <<< w) - 1;
    endfunction

    // Smallest representable output value.
    function automatic longint sat_lo(input int w, input bit s);
        return s ? -(longint'(1) <<< (w - 1)) : longint'(0);
    endfunction

endpackage

// File: rtl/systolic_array_drain_if.sv
// Row stream from the drain stage to write-back.
// master: drives out_data/out_row/out_valid/out_last; slave: drives out_ready.
interface systolic_array_drain_if
    import systolic_array_drain_pkg::*;
#(
    parameter int WIDTH_OUT = 16,
    parameter int x_axis    = 3,
    parameter int ROW_W     = row_w(3)
);
    logic [WIDTH_OUT-1:0] out_data [0:x_axis-1];
    logic [ROW_W-1:0]     out_row;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output out_data, out_row, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  out_data, out_row, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/systolic_array_drain_quant.sv
// Combinational shift + saturate/truncate of one accumulator word.
// Ports: word (WIDTH_MAC in), q (WIDTH_OUT out).
module drain_quant
    import systolic_array_drain_pkg::*;
#(
    parameter int WIDTH_MAC = 48,
    parameter int WIDTH_OUT = 16,
    parameter int SHIFT     = 0,
    parameter int SATURATE  = 1,
    parameter int SIGNED    = 0
) (
    input  logic [WIDTH_MAC-1:0] word,
    output logic [WIDTH_OUT-1:0] q
);
    localparam logic signed [WIDTH_MAC:0] HI =
        (WIDTH_MAC+1)'(sat_hi(WIDTH_OUT, SIGNED != 0));
    localparam logic signed [WIDTH_MAC:0] LO =
        (WIDTH_MAC+1)'(sat_lo(WIDTH_OUT, SIGNED != 0));

    // One extra bit lets signed and unsigned share one signed compare.
    logic signed [WIDTH_MAC:0] ext;
    logic signed [WIDTH_MAC:0] v;

    assign ext = (SIGNED != 0) ? {word[WIDTH_MAC-1], word}
                               : {1'b0, word};
    assign v   = ext >>> SHIFT;

    always_comb begin
        q = v[WIDTH_OUT-1:0];
        if (SATURATE != 0) begin
            if (v > HI)
                q = HI[WIDTH_OUT-1:0];
            else if (v < LO)
                q = LO[WIDTH_OUT-1:0];
        end
    end
endmodule

// File: rtl/systolic_array_drain.sv
// Snapshots the MAC grid on start, clears the array, streams quantised rows.
// Ports: clk, rst_n, mac_in grid, start, row_bus (master), busy, done, reg_clear_out.
module systolic_array_drain
    import systolic_array_drain_pkg::*;
#(
    parameter int WIDTH_MAC = 48,
    parameter int WIDTH_OUT = 16,
    parameter int SHIFT     = 0,
    parameter int SATURATE  = 1,
    parameter int SIGNED    = 0,
    parameter int x_axis    = 3,
    parameter int y_axis    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH_MAC-1:0] mac_in [0:y_axis-1][0:x_axis-1],
    input  logic                 start,
    systolic_array_drain_if.master row_bus,
    output logic                 busy,
    output logic                 done,
    output logic                 reg_clear_out
);
    localparam int ROW_W = row_w(y_axis);
    localparam logic [ROW_W-1:0] LAST = ROW_W'(y_axis - 1);

    drain_state_e         state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 snap, done_d, clr_d;
    logic                 done_q, clr_q;
    logic [WIDTH_MAC-1:0] snap_q [0:y_axis-1][0:x_axis-1];
    logic [WIDTH_OUT-1:0] q_row [0:x_axis-1];

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        snap    = 1'b0;
        done_d  = 1'b0;
        clr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap    = 1'b1;
                    clr_d   = 1'b1;
                    row_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (row_bus.out_ready) begin
                    if (row_q == LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            for (int r = 0; r < y_axis; r++)
                for (int c = 0; c < x_axis; c++)
                    snap_q[r][c] <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
            if (snap)
                snap_q <= mac_in;
        end
    end

    // Quantisers sit on the registered snapshot row, so the
    // beat is stable for as long as the consumer stalls.
    for (genvar c = 0; c < x_axis; c++) begin : g_q
        drain_quant #(
            .WIDTH_MAC (WIDTH_MAC),
            .WIDTH_OUT (WIDTH_OUT),
            .SHIFT     (SHIFT),
            .SATURATE  (SATURATE),
            .SIGNED    (SIGNED)
        ) u_q (
            .word (snap_q[row_q][c]),
            .q    (q_row[c])
        );
    end

    assign row_bus.out_data  = q_row;
    assign row_bus.out_row   = row_q;
    assign row_bus.out_valid = (state_q == DRAIN);
    assign row_bus.out_last  = (state_q == DRAIN) && (row_q == LAST);
    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign reg_clear_out     = clr_q;
endmodule

// File: tb/tb_systolic_array_drain.sv
// Directed bench for systolic_array_drain with a row scoreboard.
// Four instances cover default, signed-saturate, shift-truncate and y_axis=1.
module tb_systolic_array_drain;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic [47:0] a_mac [0:2][0:2];
    logic [47:0] b_mac [0:2][0:2];
    logic [47:0] c_mac [0:2][0:2];
    logic [47:0] d_mac [0:0][0:2];
    logic a_busy, a_done, a_clr;
    logic b_busy, b_done, b_clr;
    logic c_busy, c_done, c_clr;
    logic d_busy, d_done, d_clr;

    systolic_array_drain_if #(.WIDTH_OUT(16), .x_axis(3), .ROW_W(2)) a_if ();
    systolic_array_drain_if #(.WIDTH_OUT(16), .x_axis(3), .ROW_W(2)) b_if ();
    systolic_array_drain_if #(.WIDTH_OUT(16), .x_axis(3), .ROW_W(2)) c_if ();
    systolic_array_drain_if #(.WIDTH_OUT(16), .x_axis(3), .ROW_W(1)) d_if ();

    assign a_if.out_ready = ready;
    assign b_if.out_ready = ready;
    assign c_if.out_ready = ready;
    assign d_if.out_ready = ready;

    systolic_array_drain u_a (
        .clk(clk), .rst_n(rst_n), .mac_in(a_mac), .start(start),
        .row_bus(a_if), .busy(a_busy), .done(a_done), .reg_clear_out(a_clr)
    );

    systolic_array_drain #(.SIGNED(1), .SATURATE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .mac_in(b_mac), .start(start),
        .row_bus(b_if), .busy(b_busy), .done(b_done), .reg_clear_out(b_clr)
    );

    systolic_array_drain #(.SIGNED(1), .SHIFT(4), .SATURATE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .mac_in(c_mac), .start(start),
        .row_bus(c_if), .busy(c_busy), .done(c_done), .reg_clear_out(c_clr)
    );

    systolic_array_drain #(.y_axis(1)) u_d (
        .clk(clk), .rst_n(rst_n), .mac_in(d_mac), .start(start),
        .row_bus(d_if), .busy(d_busy), .done(d_done), .reg_clear_out(d_clr)
    );

    logic [47:0] a_flat, b_flat, c_flat, d_flat;
    assign a_flat = {a_if.out_data[0], a_if.out_data[1], a_if.out_data[2]};
    assign b_flat = {b_if.out_data[0], b_if.out_data[1], b_if.out_data[2]};
    assign c_flat = {c_if.out_data[0], c_if.out_data[1], c_if.out_data[2]};
    assign d_flat = {d_if.out_data[0], d_if.out_data[1], d_if.out_data[2]};

    typedef struct {
        logic [1:0]  row;
        logic        last;
        logic [47:0] data;
    } exp_t;

    exp_t sb [$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Unsigned 16-bit clamp, no shift: the default instance.
    function automatic logic [15:0] qa(input logic [47:0] x);
        return (x > 48'd65535) ? 16'hFFFF : x[15:0];
    endfunction

    task automatic push_a();
        exp_t e;
        for (int r = 0; r < 3; r++) begin
            e.row  = 2'(r);
            e.last = (r == 2);
            e.data = {qa(a_mac[r][0]), qa(a_mac[r][1]), qa(a_mac[r][2])};
            sb.push_back(e);
        end
    endtask

    task automatic fill_a(input int base, input int rs, input int cs);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                a_mac[r][c] = 48'(base + rs * r + cs * c);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!a_done && n < 12) begin
            cycle();
            n++;
        end
        chk("done_seen", 64'(a_done), 64'd1);
    endtask

    // Beats are accepted on the next rising edge, so the
    // falling edge sees exactly what the DUT will hand over.
    always @(negedge clk) begin
        if (rst_n && a_if.out_valid && a_if.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(a_if.out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("beat_row", 64'(a_if.out_row), 64'(e.row));
                chk("beat_last", 64'(a_if.out_last), 64'(e.last));
                chk("beat_data", 64'(a_flat), 64'(e.data));
            end
        end
    end

    initial begin
        fill_a(0, 10, 1);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                b_mac[r][c] = '0;
                c_mac[r][c] = '0;
            end
        b_mac[0][0] = 48'd70000;
        b_mac[0][1] = -48'sd70000;
        b_mac[0][2] = -48'sd5;
        c_mac[0][0] = -48'sd32;
        c_mac[0][1] = 48'h12345;
        c_mac[0][2] = 48'h7FFFF0;
        d_mac[0][0] = 48'd7;
        d_mac[0][1] = 48'd8;
        d_mac[0][2] = 48'd9;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(a_if.out_valid), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_clr", 64'(a_clr), 64'd0);
        chk("rst_last", 64'(a_if.out_last), 64'd0);
        chk("rst_row", 64'(a_if.out_row), 64'd0);
        chk("rst_data", 64'(a_flat), 64'd0);
        rst_n = 1'b1;
        cycle();

        // Basic drain with ready held high
        ready = 1'b1;
        start = 1'b1;
        push_a();
        cycle();
        start = 1'b0;
        chk("t1_clr", 64'(a_clr), 64'd1);
        chk("t1_valid", 64'(a_if.out_valid), 64'd1);
        chk("t1_busy", 64'(a_busy), 64'd1);
        chk("t1_row0", 64'(a_if.out_row), 64'd0);
        chk("sat_signed", 64'(b_flat), 64'h7FFF_8000_FFFB);
        chk("shift_trunc", 64'(c_flat), 64'hFFFE_1234_FFFF);
        chk("y1_last", 64'(d_if.out_last), 64'd1);
        chk("y1_data", 64'(d_flat), 64'h0007_0008_0009);
        cycle();
        chk("t1_clr_pulse", 64'(a_clr), 64'd0);
        chk("t1_row1", 64'(a_if.out_row), 64'd1);
        chk("y1_done", 64'(d_done), 64'd1);
        cycle();
        chk("t1_row2", 64'(a_if.out_row), 64'd2);
        chk("t1_last", 64'(a_if.out_last), 64'd1);
        cycle();
        chk("t1_done", 64'(a_done), 64'd1);
        chk("t1_busy_lo", 64'(a_busy), 64'd0);
        chk("t1_valid_lo", 64'(a_if.out_valid), 64'd0);
        cycle();
        chk("t1_done_pulse", 64'(a_done), 64'd0);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure on row 1
        start = 1'b1;
        push_a();
        cycle();
        start = 1'b0;
        cycle();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_row", 64'(a_if.out_row), 64'd1);
            chk("bp_valid", 64'(a_if.out_valid), 64'd1);
            chk("bp_data", 64'(a_flat), 64'h000A_000B_000C);
        end
        ready = 1'b1;
        cycle();
        chk("bp_row2", 64'(a_if.out_row), 64'd2);
        wait_done();
        cycle();

        // Snapshot isolation, ignored start, start in done cycle
        fill_a(100, 10, 1);
        start = 1'b1;
        push_a();
        cycle();
        start = 1'b0;
        chk("iso_clr", 64'(a_clr), 64'd1);
        fill_a(200, 10, 1);
        for (int r = 0; r < 3; r++)
            a_mac[r][2] = 48'(100000 + r);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("iso_no_clr", 64'(a_clr), 64'd0);
        chk("iso_busy", 64'(a_busy), 64'd1);
        wait_done();
        start = 1'b1;
        push_a();
        cycle();
        start = 1'b0;
        chk("restart_clr", 64'(a_clr), 64'd1);
        chk("restart_valid", 64'(a_if.out_valid), 64'd1);
        wait_done();
        cycle();
        chk("iso_sb_empty", 64'(sb.size()), 64'd0);

        // Reset during row 1
        fill_a(50, 3, 1);
        start = 1'b1;
        push_a();
        cycle();
        start = 1'b0;
        cycle();
        chk("pre_rst_row", 64'(a_if.out_row), 64'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_valid", 64'(a_if.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(a_busy), 64'd0);
        chk("mid_rst_row", 64'(a_if.out_row), 64'd0);
        chk("mid_rst_data", 64'(a_flat), 64'd0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("mid_rst_done", 64'(a_done), 64'd0);
            chk("mid_rst_clr", 64'(a_clr), 64'd0);
        end
        rst_n = 1'b1;
        cycle();
        fill_a(1000, 1000, 7);
        start = 1'b1;
        push_a();
        cycle();
        start = 1'b0;
        chk("post_rst_clr", 64'(a_clr), 64'd1);
        wait_done();
        cycle();
        chk("post_rst_sb", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
